// File: rtl/corelet_seq_ctrl.sv
// Corelet sequencer: per-kij weight load/shift, activation load/exec, weight clear, then output write-back.
// Optional perf counters are enabled with `define CSEQ_PERF_CNT_EN.
module corelet_seq_ctrl #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int ADDR_W   = 7,
  parameter int OADDR_W  = 4,
  parameter int KIJ_W    = 4,
  parameter int N_OUT    = 16,
  parameter int W_SETTLE = 16,
  parameter int DRAIN    = 22
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_seq_begin,
  input  logic               i_abort,
  input  logic [KIJ_W-1:0]   i_cfg_kij_num,
  input  logic [ADDR_W-1:0]  i_cfg_act_len,
  input  logic [ADDR_W-1:0]  i_cfg_w_base,
  input  logic [ADDR_W-1:0]  i_cfg_act_base,
  input  logic [OADDR_W-1:0] i_cfg_op_base,
  input  logic               i_l0_full,
  output logic [ADDR_W-1:0]  o_w_addr,
  output logic [ADDR_W-1:0]  o_act_addr,
  output logic               o_w_cen,
  output logic               o_act_cen,
  output logic               o_w_wen,
  output logic               o_act_wen,
  output logic               o_aw_mode,
  output logic               o_l0_wr,
  output logic               o_l0_rd,
  output logic [1:0]         o_inst_w,
  output logic               o_weight_reset,
  output logic [OADDR_W-1:0] o_op_addr,
  output logic               o_op_cen,
  output logic               o_op_wen,
  output logic [OADDR_W-1:0] o_sfu_idx,
  output logic               o_busy,
  output logic               o_seq_done,
  output logic [31:0]        o_perf_busy_cyc,
  output logic [31:0]        o_perf_stall_cyc
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_W_LOAD, S_W_SHIFT, S_A_LOAD, S_A_EXEC, S_W_CLEAR, S_WB, S_DONE
  } state_t;

  state_t              r_state, w_nxt_state;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
  logic [CNT_W-1:0]    r_idx, w_nxt_idx;
  logic [KIJ_W-1:0]    r_kij, w_nxt_kij;
  logic                r_rd;

  logic [KIJ_W-1:0]    r_kij_num;
  logic [CNT_W-1:0]    r_act_len;
  logic [ADDR_W-1:0]   r_w_base, r_act_base;
  logic [OADDR_W-1:0]  r_op_base;

  logic                w_start;
  logic [ADDR_W-1:0]   w_w_base;

  logic                w_rd_ok, w_rd_d, w_aw_d, w_l0_rd_d, w_wrst_d, w_op_d, w_done_d;
  logic [1:0]          w_inst_d;
  logic [ADDR_W-1:0]   w_w_addr_d, w_act_addr_d;
  logic [OADDR_W-1:0]  w_op_addr_d, w_sfu_d;

  assign w_start  = (r_state == S_IDLE) && i_seq_begin && !i_abort;
  assign w_w_base = w_start ? i_cfg_w_base : r_w_base;
  assign o_w_wen   = 1'b1;
  assign o_act_wen = 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_kij      <= '0;
      r_kij_num  <= '0;
      r_act_len  <= '0;
      r_w_base   <= '0;
      r_act_base <= '0;
      r_op_base  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_idx   <= w_nxt_idx;
      r_kij   <= w_nxt_kij;
      if (w_start) begin
        r_kij_num  <= (i_cfg_kij_num == '0) ? KIJ_W'(1) : i_cfg_kij_num;
        r_act_len  <= (i_cfg_act_len == '0) ? CNT_W'(1) : CNT_W'(i_cfg_act_len);
        r_w_base   <= i_cfg_w_base;
        r_act_base <= i_cfg_act_base;
        r_op_base  <= i_cfg_op_base;
      end
    end
  end

  // r_idx counts reads already issued; a load state ends after the tail cycle where it reaches its length.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx + CNT_W'(r_rd);
    w_nxt_kij   = r_kij;
    case (r_state)
      S_IDLE: begin
        w_nxt_idx = '0;
        if (i_seq_begin) begin
          w_nxt_state = S_W_LOAD;
          w_nxt_cnt   = '0;
          w_nxt_kij   = '0;
        end
      end
      S_W_LOAD:
        if (r_idx == CNT_W'(ROW)) begin
          w_nxt_state = S_W_SHIFT;
          w_nxt_cnt   = '0;
          w_nxt_idx   = '0;
        end
      S_W_SHIFT:
        if (r_cnt == CNT_W'(COL + W_SETTLE - 1)) begin
          w_nxt_state = S_A_LOAD;
          w_nxt_cnt   = '0;
          w_nxt_idx   = '0;
        end else w_nxt_cnt = r_cnt + 1'b1;
      S_A_LOAD:
        if (r_idx == r_act_len) begin
          w_nxt_state = S_A_EXEC;
          w_nxt_cnt   = '0;
          w_nxt_idx   = '0;
        end
      S_A_EXEC:
        if (r_cnt == r_act_len + CNT_W'(DRAIN - 1)) begin
          w_nxt_state = S_W_CLEAR;
          w_nxt_cnt   = '0;
        end else w_nxt_cnt = r_cnt + 1'b1;
      S_W_CLEAR: begin
        w_nxt_cnt = '0;
        w_nxt_idx = '0;
        if (r_kij == r_kij_num - 1'b1) w_nxt_state = S_WB;
        else begin
          w_nxt_state = S_W_LOAD;
          w_nxt_kij   = r_kij + 1'b1;
        end
      end
      S_WB:
        if (r_cnt == CNT_W'(N_OUT - 1)) begin
          w_nxt_state = S_DONE;
          w_nxt_cnt   = '0;
        end else w_nxt_cnt = r_cnt + 1'b1;
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    if (i_abort) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
      w_nxt_idx   = '0;
    end
  end

  // Outputs are decoded from the next state so the registered strobes line up with the state cycle.
  always_comb begin
    w_rd_ok      = 1'b0;
    w_aw_d       = 1'b0;
    w_l0_rd_d    = 1'b0;
    w_inst_d     = 2'b00;
    w_wrst_d     = 1'b0;
    w_op_d       = 1'b0;
    w_done_d     = 1'b0;
    w_w_addr_d   = '0;
    w_act_addr_d = '0;
    w_op_addr_d  = '0;
    w_sfu_d      = '0;
    case (w_nxt_state)
      S_W_LOAD: begin
        w_aw_d     = 1'b1;
        w_rd_ok    = (w_nxt_idx < CNT_W'(ROW));
        w_w_addr_d = w_w_base + ADDR_W'(w_nxt_kij) * ADDR_W'(ROW) + w_nxt_idx[ADDR_W-1:0];
      end
      S_W_SHIFT: begin
        w_aw_d = 1'b1;
        if (w_nxt_cnt < CNT_W'(COL)) begin
          w_l0_rd_d = 1'b1;
          w_inst_d  = 2'b01;
        end
      end
      S_A_LOAD: begin
        w_rd_ok      = (w_nxt_idx < r_act_len);
        w_act_addr_d = r_act_base + w_nxt_idx[ADDR_W-1:0];
      end
      S_A_EXEC:
        if (w_nxt_cnt < r_act_len) begin
          w_l0_rd_d = 1'b1;
          w_inst_d  = 2'b10;
        end
      S_W_CLEAR: w_wrst_d = 1'b1;
      S_WB: begin
        w_op_d      = 1'b1;
        w_op_addr_d = r_op_base + w_nxt_cnt[OADDR_W-1:0];
        w_sfu_d     = w_nxt_cnt[OADDR_W-1:0];
      end
      S_DONE:  w_done_d = 1'b1;
      default: ;
    endcase
  end

  assign w_rd_d = w_rd_ok && !i_l0_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd           <= 1'b0;
      o_w_addr       <= '0;
      o_act_addr     <= '0;
      o_w_cen        <= 1'b1;
      o_act_cen      <= 1'b1;
      o_aw_mode      <= 1'b0;
      o_l0_wr        <= 1'b0;
      o_l0_rd        <= 1'b0;
      o_inst_w       <= 2'b00;
      o_weight_reset <= 1'b0;
      o_op_addr      <= '0;
      o_op_cen       <= 1'b1;
      o_op_wen       <= 1'b1;
      o_sfu_idx      <= '0;
      o_busy         <= 1'b0;
      o_seq_done     <= 1'b0;
    end else begin
      r_rd           <= w_rd_d;
      o_w_addr       <= w_w_addr_d;
      o_act_addr     <= w_act_addr_d;
      o_w_cen        <= !(w_rd_d && w_nxt_state == S_W_LOAD);
      o_act_cen      <= !(w_rd_d && w_nxt_state == S_A_LOAD);
      o_aw_mode      <= w_aw_d;
      o_l0_wr        <= r_rd && !i_abort;
      o_l0_rd        <= w_l0_rd_d;
      o_inst_w       <= w_inst_d;
      o_weight_reset <= w_wrst_d;
      o_op_addr      <= w_op_addr_d;
      o_op_cen       <= !w_op_d;
      o_op_wen       <= !w_op_d;
      o_sfu_idx      <= w_sfu_d;
      o_busy         <= (w_nxt_state != S_IDLE);
      o_seq_done     <= w_done_d;
    end
  end

`ifdef CSEQ_PERF_CNT_EN
  logic        r_stall;
  logic [31:0] r_busy_cyc, r_stall_cyc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall     <= 1'b0;
      r_busy_cyc  <= '0;
      r_stall_cyc <= '0;
    end else begin
      r_stall <= w_rd_ok && i_l0_full && !i_abort;
      if (w_start) begin
        r_busy_cyc  <= '0;
        r_stall_cyc <= '0;
      end else begin
        if (o_busy && r_busy_cyc != '1)  r_busy_cyc  <= r_busy_cyc + 1'b1;
        if (r_stall && r_stall_cyc != '1) r_stall_cyc <= r_stall_cyc + 1'b1;
      end
    end
  end

  assign o_perf_busy_cyc  = r_busy_cyc;
  assign o_perf_stall_cyc = r_stall_cyc;
`else
  assign o_perf_busy_cyc  = '0;
  assign o_perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_corelet_seq_ctrl.sv
// Directed self-checking bench for corelet_seq_ctrl with hand-computed cycle counts and address sequences.
module tb_corelet_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset, i_seq_begin, i_abort, i_l0_full;
  logic [3:0]  i_cfg_kij_num;
  logic [6:0]  i_cfg_act_len, i_cfg_w_base, i_cfg_act_base;
  logic [3:0]  i_cfg_op_base;
  logic [6:0]  o_w_addr, o_act_addr;
  logic        o_w_cen, o_act_cen, o_w_wen, o_act_wen, o_aw_mode, o_l0_wr, o_l0_rd;
  logic [1:0]  o_inst_w;
  logic        o_weight_reset;
  logic [3:0]  o_op_addr, o_sfu_idx;
  logic        o_op_cen, o_op_wen, o_busy, o_seq_done;
  logic [31:0] o_perf_busy_cyc, o_perf_stall_cyc;

  corelet_seq_ctrl #(.ROW(8), .COL(8), .ADDR_W(7), .OADDR_W(4), .KIJ_W(4),
                     .N_OUT(16), .W_SETTLE(16), .DRAIN(22)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_seq_begin(i_seq_begin), .i_abort(i_abort),
    .i_cfg_kij_num(i_cfg_kij_num), .i_cfg_act_len(i_cfg_act_len),
    .i_cfg_w_base(i_cfg_w_base), .i_cfg_act_base(i_cfg_act_base),
    .i_cfg_op_base(i_cfg_op_base), .i_l0_full(i_l0_full),
    .o_w_addr(o_w_addr), .o_act_addr(o_act_addr), .o_w_cen(o_w_cen), .o_act_cen(o_act_cen),
    .o_w_wen(o_w_wen), .o_act_wen(o_act_wen), .o_aw_mode(o_aw_mode), .o_l0_wr(o_l0_wr),
    .o_l0_rd(o_l0_rd), .o_inst_w(o_inst_w), .o_weight_reset(o_weight_reset),
    .o_op_addr(o_op_addr), .o_op_cen(o_op_cen), .o_op_wen(o_op_wen), .o_sfu_idx(o_sfu_idx),
    .o_busy(o_busy), .o_seq_done(o_seq_done),
    .o_perf_busy_cyc(o_perf_busy_cyc), .o_perf_stall_cyc(o_perf_stall_cyc)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // per-run observations
  int          done_cyc, wrst_cnt, op_cnt, inst01_cnt, inst10_cnt, l0wr_cnt;
  int          op_hits[16];
  logic [6:0]  wq[$], aq[$];
  logic [31:0] perf_busy, perf_stall;
  logic        post_abort_busy, post_abort_opcen;

  task automatic run(input int k, input int len, input int wbase, input int abase, input int obase,
                     input int stall_at, input int stall_len, input int begin_at,
                     input int abort_at, input int budget);
    int n;
    done_cyc = -1; wrst_cnt = 0; op_cnt = 0; inst01_cnt = 0; inst10_cnt = 0; l0wr_cnt = 0;
    perf_busy = '0; perf_stall = '0; post_abort_busy = 1'bx; post_abort_opcen = 1'bx;
    for (int i = 0; i < 16; i++) op_hits[i] = 0;
    wq.delete(); aq.delete();
    i_cfg_kij_num  = 4'(k);
    i_cfg_act_len  = 7'(len);
    i_cfg_w_base   = 7'(wbase);
    i_cfg_act_base = 7'(abase);
    i_cfg_op_base  = 4'(obase);
    i_seq_begin    = 1'b1;
    @(posedge i_clk); #1;
    i_seq_begin = 1'b0;
    n = 0;
    while (n < budget && done_cyc < 0) begin
      if (!o_w_cen) wq.push_back(o_w_addr);
      if (!o_act_cen) aq.push_back(o_act_addr);
      if (o_weight_reset) wrst_cnt++;
      if (o_l0_wr) l0wr_cnt++;
      if (o_inst_w == 2'b01) inst01_cnt++;
      if (o_inst_w == 2'b10) inst10_cnt++;
      if (!o_op_cen && !o_op_wen) begin
        op_cnt++;
        op_hits[o_op_addr]++;
      end
      if (n == abort_at + 1) begin
        post_abort_busy  = o_busy;
        post_abort_opcen = o_op_cen;
      end
      if (o_seq_done) begin
        done_cyc   = n;
        perf_busy  = o_perf_busy_cyc;
        perf_stall = o_perf_stall_cyc;
      end
      i_l0_full   = (n >= stall_at) && (n < stall_at + stall_len);
      i_seq_begin = (n == begin_at);
      i_abort     = (n == abort_at);
      @(posedge i_clk); #1;
      n++;
    end
    i_l0_full = 1'b0; i_seq_begin = 1'b0; i_abort = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  int exp_busy145, exp_stall3;
  int errs;

  initial begin
`ifdef CSEQ_PERF_CNT_EN
    exp_busy145 = 145; exp_stall3 = 3;
`else
    exp_busy145 = 0;   exp_stall3 = 0;
`endif
    i_reset = 1'b1; i_seq_begin = 1'b0; i_abort = 1'b0; i_l0_full = 1'b0;
    i_cfg_kij_num = '0; i_cfg_act_len = '0; i_cfg_w_base = '0; i_cfg_act_base = '0; i_cfg_op_base = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_w_cen",   32'(o_w_cen), 1);
    check("rst_act_cen", 32'(o_act_cen), 1);
    check("rst_op_cen",  32'(o_op_cen), 1);
    check("rst_op_wen",  32'(o_op_wen), 1);
    check("rst_busy",    32'(o_busy), 0);
    check("rst_done",    32'(o_seq_done), 0);
    check("rst_inst",    32'(o_inst_w), 0);
    check("rst_perf",    o_perf_busy_cyc, 0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // seq_begin together with abort in IDLE: stays idle
    i_seq_begin = 1'b1; i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_seq_begin = 1'b0; i_abort = 1'b0;
    check("beg_abort_busy", 32'(o_busy), 0);
    check("beg_abort_cen",  32'(o_w_cen), 1);
    @(posedge i_clk); #1;
    check("beg_abort_busy2", 32'(o_busy), 0);

    // K=9 defaults, op_base 5 so writes wrap
    run(9, 36, 0, 0, 5, -10, 0, -10, -10, 1300);
    check("t1_done", done_cyc, 1177);
    check("t1_wrst", wrst_cnt, 9);
    check("t1_op_cnt", op_cnt, 16);
    for (int i = 0; i < 16; i++) check($sformatf("t1_op_hit%0d", i), op_hits[i], 1);
    check("t1_wq_len", wq.size(), 72);
    errs = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] != 7'(i)) errs++;
    check("t1_wq_seq", errs, 0);
    check("t1_aq_len", aq.size(), 9 * 36);
    check("t1_inst01", inst01_cnt, 9 * 8);
    check("t1_inst10", inst10_cnt, 9 * 36);
    check("t1_l0wr", l0wr_cnt, 9 * (8 + 36));

    // K=1, w_base 8
    run(1, 36, 8, 0, 0, -10, 0, -10, -10, 300);
    check("t2_done", done_cyc, 145);
    check("t2_wq_len", wq.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_waddr%0d", i), 32'(wq[i]), 32'(8 + i));
    check("t2_perf_busy", perf_busy, 32'(exp_busy145));
    check("t2_perf_stall", perf_stall, 0);

    // l0_full for three cycles in the middle of A_LOAD
    run(1, 36, 0, 20, 0, 40, 3, -10, -10, 300);
    check("t3_done", done_cyc, 148);
    check("t3_aq_len", aq.size(), 36);
    errs = 0;
    for (int i = 0; i < aq.size(); i++) if (aq[i] != 7'(20 + i)) errs++;
    check("t3_aq_seq", errs, 0);
    check("t3_perf_stall", perf_stall, 32'(exp_stall3));

    // abort in WB cycle 5 (cycle 134)
    run(1, 36, 0, 0, 0, -10, 0, -10, 134, 170);
    check("t4_busy_after", 32'(post_abort_busy), 0);
    check("t4_opcen_after", 32'(post_abort_opcen), 1);
    check("t4_no_done", done_cyc, 32'hffffffff);
    check("t4_op_cnt", op_cnt, 6);

    run(1, 36, 0, 0, 0, -10, 0, -10, -10, 300);
    check("t5_rerun_done", done_cyc, 145);

    // seq_begin during A_EXEC is ignored
    run(1, 36, 0, 0, 0, -10, 0, 80, -10, 300);
    check("t6_done", done_cyc, 145);

    // zero config treated as 1/1
    run(0, 0, 0, 0, 0, -10, 0, -10, -10, 200);
    check("t7_done", done_cyc, 75);
    check("t7_wrst", wrst_cnt, 1);
    check("t7_aq_len", aq.size(), 1);
    check("t7_inst10", inst10_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
